// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester agent: per-channel state encoding and
// default widths.
package arb_pkg;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t ST_IDLE = 2'd0;
  localparam chan_state_t ST_WAIT = 2'd1;
  localparam chan_state_t ST_OWN  = 2'd2;
  localparam chan_state_t ST_DONE = 2'd3;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned LW_DEF = 4;

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: accepts a job and requests the arbiter. It consumes one beat per
// granted cycle and reports completion, preemption and starvation.
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int unsigned LW         = LW_DEF,
  parameter int unsigned SW         = 6,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_job_valid,
  input  logic [LW-1:0] i_job_len,
  input  logic          i_gnt,
  output logic          o_job_ready,
  output logic          o_req,
  output logic          o_beat,
  output logic          o_done,
  output logic          o_preempt,
  output logic          o_starve
);

  chan_state_t   r_state, w_state_d;
  logic [LW-1:0] r_rem, w_rem_d;
  logic [SW-1:0] r_wait, w_wait_d;
  logic          r_req, r_done, r_preempt, r_starve;
  logic          w_req_d, w_done_d, w_preempt_d, w_starve_d, w_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_wait    <= '0;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_preempt <= 1'b0;
      r_starve  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rem     <= w_rem_d;
      r_wait    <= w_wait_d;
      r_req     <= w_req_d;
      r_done    <= w_done_d;
      r_preempt <= w_preempt_d;
      r_starve  <= w_starve_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_rem_d   = r_rem;
    case (r_state)
      ST_IDLE: begin
        if (i_job_valid) begin
          if (i_job_len != '0) begin
            w_state_d = ST_WAIT;
            w_rem_d   = i_job_len;
          end else begin
            w_state_d = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (i_gnt) w_state_d = (r_rem > LW'(1)) ? ST_OWN : ST_DONE;
      end
      ST_OWN: begin
        if (!i_gnt)                w_state_d = ST_WAIT;
        else if (r_rem == LW'(1))  w_state_d = ST_DONE;
      end
      default: w_state_d = ST_IDLE;
    endcase
    // Guarded decrement keeps rem from wrapping below zero.
    if (w_beat && (r_rem != '0)) w_rem_d = r_rem - LW'(1);
  end

  always_comb begin
    w_beat      = i_gnt && ((r_state == ST_WAIT) || (r_state == ST_OWN));
    o_job_ready = (r_state == ST_IDLE);
    w_req_d     = (w_state_d == ST_WAIT) || (w_state_d == ST_OWN);
    w_done_d    = (w_state_d == ST_DONE) && (r_state != ST_DONE);
    w_preempt_d = (r_state == ST_OWN) && !i_gnt;
    w_starve_d  = (r_state == ST_WAIT) && (r_wait >= SW'(STARVE_LIM));
    w_wait_d    = '0;
    if ((r_state == ST_WAIT) && !i_gnt) w_wait_d = (r_wait == '1) ? r_wait : r_wait + SW'(1);
  end

  assign o_beat    = w_beat;
  assign o_req     = r_req;
  assign o_done    = r_done;
  assign o_preempt = r_preempt;
  assign o_starve  = r_starve;

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for a fixed-priority arbiter: N independent channels plus a
// registered check that flags grants to more than one channel or to an idle channel.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned LW         = LW_DEF,
  parameter int unsigned SW         = 6,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  i_Job_Valid,
  input  logic [N*LW-1:0] i_Job_Len,
  output logic [N-1:0]  o_Job_Ready,
  output logic [N-1:0]  o_Req,
  input  logic [N-1:0]  i_Gnt,
  output logic [N-1:0]  o_Beat,
  output logic [N-1:0]  o_Done,
  output logic [N-1:0]  o_Preempt,
  output logic [N-1:0]  o_Starve,
  output logic          o_Gnt_Err
);

  logic w_multi, w_seen, w_idle_gnt, r_gnt_err;

  for (genvar k = 0; k < N; k++) begin : g_chan
    arb_req_chan #(
      .LW         (LW),
      .SW         (SW),
      .STARVE_LIM (STARVE_LIM)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .i_job_valid (i_Job_Valid[k]),
      .i_job_len   (i_Job_Len[k*LW +: LW]),
      .i_gnt       (i_Gnt[k]),
      .o_job_ready (o_Job_Ready[k]),
      .o_req       (o_Req[k]),
      .o_beat      (o_Beat[k]),
      .o_done      (o_Done[k]),
      .o_preempt   (o_Preempt[k]),
      .o_starve    (o_Starve[k])
    );
  end

  always_comb begin
    w_multi = 1'b0;
    w_seen  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_Gnt[k]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
    w_idle_gnt = |(i_Gnt & o_Job_Ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_gnt_err <= 1'b0;
    else       r_gnt_err <= w_multi || w_idle_gnt;
  end

  assign o_Gnt_Err = r_gnt_err;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: a registered fixed-priority arbiter closes the loop, a job-level
// model predicts every output each cycle, and directed scenarios pin the model with literals.
module tb_arb_requester;

  localparam int N = 4;
  localparam int LW = 4;
  localparam int STARVE_LIM = 8;
  localparam int WAIT_MAX = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  i_Job_Valid;
  logic [N*LW-1:0] i_Job_Len;
  logic [N-1:0]  o_Job_Ready, o_Req, i_Gnt, o_Beat, o_Done, o_Preempt, o_Starve;
  logic          o_Gnt_Err;

  arb_requester #(.N(N), .LW(LW), .SW(6), .STARVE_LIM(STARVE_LIM)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_Job_Valid (i_Job_Valid),
    .i_Job_Len   (i_Job_Len),
    .o_Job_Ready (o_Job_Ready),
    .o_Req       (o_Req),
    .i_Gnt       (i_Gnt),
    .o_Beat      (o_Beat),
    .o_Done      (o_Done),
    .o_Preempt   (o_Preempt),
    .o_Starve    (o_Starve),
    .o_Gnt_Err   (o_Gnt_Err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Job-level model: a channel either holds an outstanding job (busy) or not.
  bit m_busy[N], m_owned[N], m_fin[N];
  int m_rem[N], m_wait[N];
  bit [N-1:0] e_done, e_pre, e_starve;
  bit e_err;
  logic [N-1:0] arb_q;
  bit force_en;
  logic [N-1:0] force_val;

  // Observations for the directed literal checks.
  int beat_cnt[N], done_cnt[N], pre_cnt[N], starve_first[N], done_cyc[N];
  logic [N-1:0] obs_req, obs_beat, obs_done, obs_starve;
  logic obs_err;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 0; m_owned[k] = 0; m_fin[k] = 0; m_rem[k] = 0; m_wait[k] = 0;
    end
    e_done = '0; e_pre = '0; e_starve = '0; e_err = 0; arb_q = '0;
  endtask

  task automatic clear_obs();
    for (int k = 0; k < N; k++) begin
      beat_cnt[k] = 0; done_cnt[k] = 0; pre_cnt[k] = 0; starve_first[k] = -1; done_cyc[k] = -1;
    end
  endtask

  function automatic logic [N-1:0] prio_pick(input logic [N-1:0] req);
    for (int k = N - 1; k >= 0; k--) if (req[k]) return N'(1) << k;
    return '0;
  endfunction

  // One clock cycle: drive grant, compare all outputs, advance model and arbiter.
  task automatic step();
    logic [N-1:0] g, x_ready, x_req, x_beat, arb_n;
    bit n_busy[N], n_owned[N], n_fin[N];
    int n_rem[N], n_wait[N];
    bit [N-1:0] n_done, n_pre, n_starve;
    int ones;
    g = force_en ? force_val : arb_q;
    i_Gnt = g;
    #1;
    for (int k = 0; k < N; k++) begin
      x_ready[k] = !m_busy[k] && !m_fin[k];
      x_req[k]   = m_busy[k];
      x_beat[k]  = g[k] && m_busy[k];
    end
    chk("ready", 32'(o_Job_Ready), 32'(x_ready));
    chk("req", 32'(o_Req), 32'(x_req));
    chk("beat", 32'(o_Beat), 32'(x_beat));
    chk("done", 32'(o_Done), 32'(e_done));
    chk("preempt", 32'(o_Preempt), 32'(e_pre));
    chk("starve", 32'(o_Starve), 32'(e_starve));
    chk("gnt_err", 32'(o_Gnt_Err), 32'(e_err));
    obs_req = o_Req; obs_beat = o_Beat; obs_done = o_Done; obs_starve = o_Starve;
    obs_err = o_Gnt_Err;
    for (int k = 0; k < N; k++) begin
      if (o_Beat[k]) beat_cnt[k]++;
      if (o_Done[k]) begin done_cnt[k]++; done_cyc[k] = cyc; end
      if (o_Preempt[k]) pre_cnt[k]++;
      if (o_Starve[k] && starve_first[k] < 0) starve_first[k] = cyc;
    end
    ones = 0;
    for (int k = 0; k < N; k++) ones += int'(g[k]);
    for (int k = 0; k < N; k++) begin
      n_busy[k] = m_busy[k]; n_owned[k] = m_owned[k]; n_fin[k] = 0; n_rem[k] = m_rem[k];
      n_pre[k]    = m_busy[k] && m_owned[k] && !g[k];
      n_starve[k] = m_busy[k] && !m_owned[k] && (m_wait[k] >= STARVE_LIM);
      n_wait[k]   = (m_busy[k] && !m_owned[k] && !g[k]) ?
                    ((m_wait[k] < WAIT_MAX) ? m_wait[k] + 1 : WAIT_MAX) : 0;
      if (m_fin[k]) begin
        n_fin[k] = 0;
      end else if (!m_busy[k]) begin
        if (i_Job_Valid[k]) begin
          if (i_Job_Len[k*LW +: LW] != 0) begin
            n_busy[k] = 1; n_rem[k] = int'(i_Job_Len[k*LW +: LW]); n_owned[k] = 0;
          end else begin
            n_fin[k] = 1;
          end
        end
      end else if (g[k]) begin
        n_rem[k] = m_rem[k] - 1;
        n_owned[k] = (n_rem[k] != 0);
        if (n_rem[k] == 0) begin n_busy[k] = 0; n_fin[k] = 1; end
      end else begin
        n_owned[k] = 0;
      end
      n_done[k] = n_fin[k];
    end
    arb_n = prio_pick(o_Req);
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      m_busy[k] = n_busy[k]; m_owned[k] = n_owned[k]; m_fin[k] = n_fin[k];
      m_rem[k] = n_rem[k]; m_wait[k] = n_wait[k];
    end
    e_done = n_done; e_pre = n_pre; e_starve = n_starve;
    e_err = (ones > 1) || ((g & x_ready) != '0);
    arb_q = arb_n;
    @(negedge clk);
    cyc++;
  endtask

  task automatic offer(input logic [N-1:0] valid, input logic [N*LW-1:0] len);
    i_Job_Valid = valid;
    i_Job_Len = len;
    step();
    i_Job_Valid = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int start;
    bit reached;
    reset = 1'b1; i_Job_Valid = '0; i_Job_Len = '0; i_Gnt = '0;
    force_en = 0; force_val = '0;
    model_reset();
    clear_obs();
    #2;
    chk("rst_ready", 32'(o_Job_Ready), 32'hf);
    chk("rst_req", 32'(o_Req), 32'h0);
    chk("rst_flags", 32'({o_Done, o_Preempt, o_Starve, o_Gnt_Err}), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Single job on ch1, Len=3.
    clear_obs(); start = cyc;
    offer(4'b0010, 16'h0030);
    step();
    chk("s1_req", 32'(obs_req), 32'h2);
    run(8);
    chk("s1_beats", 32'(beat_cnt[1]), 3);
    chk("s1_done_cnt", 32'(done_cnt[1]), 1);
    chk("s1_done_cyc", 32'(done_cyc[1] - start), 5);
    chk("s1_ready", 32'(o_Job_Ready[1]), 1);

    // Preemption of ch0 (Len=5) by ch3 (Len=2).
    clear_obs();
    offer(4'b0001, 16'h0005);
    step();
    offer(4'b1000, 16'h2000);
    run(15);
    chk("s2_beats0", 32'(beat_cnt[0]), 5);
    chk("s2_pre0", 32'(pre_cnt[0]), 1);
    chk("s2_beats3", 32'(beat_cnt[3]), 2);

    // Starvation: ch3 Len=15 and ch0 Len=1 together.
    clear_obs(); start = cyc;
    offer(4'b1001, 16'hf001);
    run(25);
    chk("s3_starve_rise", 32'(starve_first[0] - start), 10);
    chk("s3_done3", 32'(done_cyc[3] - start), 17);
    chk("s3_done0", 32'(done_cyc[0] - start), 19);
    chk("s3_starve_clr", 32'(obs_starve[0]), 0);

    // Zero-length job on ch2.
    clear_obs();
    offer(4'b0100, 16'h0000);
    step();
    chk("s4_done", 32'(obs_done), 32'h4);
    chk("s4_req", 32'(obs_req[2]), 0);
    run(3);
    chk("s4_beats", 32'(beat_cnt[2]), 0);
    chk("s4_done_cnt", 32'(done_cnt[2]), 1);

    // Illegal grants.
    clear_obs();
    force_en = 1; force_val = '0;
    offer(4'b0110, 16'h0440);
    step();
    force_val = 4'b0110; step();
    chk("s5_multi_beat", 32'(obs_beat), 32'h6);
    force_val = 4'b0000; step();
    chk("s5_multi_err", 32'(obs_err), 1);
    force_val = 4'b0001; step();
    force_val = 4'b0000; step();
    chk("s5_idle_err", 32'(obs_err), 1);
    force_en = 0;
    run(20);

    // Reset mid-job: ch2 Len=6, assert after 3 beats.
    clear_obs();
    offer(4'b0100, 16'h0600);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step();
      reached = (beat_cnt[2] == 3);
    end
    chk("s6_reached", 32'(reached), 1);
    #2 reset = 1'b1;
    #1;
    chk("s6_req", 32'(o_Req), 32'h0);
    chk("s6_ready", 32'(o_Job_Ready), 32'hf);
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    clear_obs();
    run(10);
    chk("s6_no_done", 32'(done_cnt[2]), 0);

    // Randomized traffic with occasional rogue grants.
    for (int i = 0; i < 1500; i++) begin
      i_Job_Valid = N'($urandom);
      i_Job_Len = (N*LW)'($urandom);
      force_en = ($urandom_range(9) == 0);
      force_val = N'($urandom);
      step();
    end
    force_en = 0; i_Job_Valid = '0;
    run(40);
    chk("final_idle", 32'(o_Job_Ready), 32'hf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
